// File: rtl/imm_decode_reg_pkg.sv
// Shared pipeline definitions for the decode register:
// opcodes needing special extension, buffer states, entry record.
package imm_decode_reg_pkg;

   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_XORI = 6'h0E;
   localparam logic [5:0] OP_LUI  = 6'h0F;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  funct;
      logic [31:0] imm;
   } entry_t;

   function automatic entry_t make_entry(
      input logic [31:0] pc,
      input logic [31:0] instr,
      input logic [31:0] imm
   );
      entry_t e;
      e.pc    = pc;
      e.op    = instr[31:26];
      e.rs    = instr[25:21];
      e.rt    = instr[20:16];
      e.rd    = instr[15:11];
      e.shamt = instr[10:6];
      e.funct = instr[5:0];
      e.imm   = imm;
      return e;
   endfunction

endpackage

// File: rtl/imm_decode_reg_imm_ext.sv
// MIPS I-type immediate extension: zero for logical ops,
// upper-half placement for LUI, sign extension otherwise.
module imm_ext
   import imm_decode_reg_pkg::*;
(
   input  logic [31:0] instr,
   output logic [31:0] imm
);

   logic [5:0] op;
   logic       is_zext;
   logic       is_lui;
   logic       unused_bits;

   assign op      = instr[31:26];
   assign is_zext = (op == OP_ANDI) || (op == OP_ORI) ||
                    (op == OP_XORI);
   assign is_lui  = (op == OP_LUI);

   assign unused_bits = ^instr[25:16];

   always_comb begin
      imm = {{16{instr[15]}}, instr[15:0]};
      unique case (1'b1)
         is_zext: imm = {16'h0000, instr[15:0]};
         is_lui:  imm = {instr[15:0], 16'h0000};
         default: ;
      endcase
   end

endmodule

// File: rtl/imm_decode_reg.sv
// IF/ID register with field split, stored immediate and
// a two-entry skid buffer so in_ready never sees out_ready.
module imm_decode_reg
   import imm_decode_reg_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int SKID_EN = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [5:0]      out_op,
   output logic [5:0]      out_funct,
   output logic [4:0]      out_rs,
   output logic [4:0]      out_rt,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_shamt,
   output logic [XLEN-1:0] out_imm
);

   localparam bit SKID = (SKID_EN != 0);

   state_t      state;
   entry_t      main_q;
   entry_t      skid_q;
   entry_t      nx;
   logic [31:0] ext_imm;
   logic        main_v;
   logic        skid_v;
   logic        acc;
   logic        drn;

   imm_ext u_ext (
      .instr (in_instr),
      .imm   (ext_imm)
   );

   assign nx     = make_entry(in_pc, in_instr, ext_imm);
   assign main_v = (state != EMPTY);
   assign skid_v = (state == TWO);

   // Without skid storage, readiness must follow the consumer.
   assign in_ready = SKID ? !skid_v : (out_ready || !main_v);
   assign acc      = in_valid && in_ready;
   assign drn      = main_v && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else if (flush) begin
         state <= EMPTY;
      end else begin
         unique case (state)
            EMPTY: begin
               if (acc) begin
                  main_q <= nx;
                  state  <= ONE;
               end
            end
            ONE: begin
               if (acc && !drn && SKID) begin
                  skid_q <= nx;
                  state  <= TWO;
               end else if (acc) begin
                  main_q <= nx;
               end else if (drn) begin
                  state <= EMPTY;
               end
            end
            TWO: begin
               if (drn) begin
                  main_q <= skid_q;
                  state  <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   assign out_valid = main_v;
   assign out_pc    = main_q.pc;
   assign out_op    = main_q.op;
   assign out_funct = main_q.funct;
   assign out_rs    = main_q.rs;
   assign out_rt    = main_q.rt;
   assign out_rd    = main_q.rd;
   assign out_shamt = main_q.shamt;
   assign out_imm   = main_q.imm;

endmodule
